// File: rtl/logic_processor_n.sv
// logic_processor_n: two WIDTH-bit registers A and B with a digit-serial bitwise
// unit. Execute applies one of eight functions DIGIT bits per clock and routes
// the result back into A and/or B. F and R are latched when the operation starts.
// Optional build macro LOGIC_PROC_HEX_OUT_EN adds registered seven-segment
// outputs (active-low, gfedcba) for every nibble of A and B.
module logic_processor_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Din,
    input  logic [2:0]       F,
    input  logic [1:0]       R,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Busy,
`ifdef LOGIC_PROC_HEX_OUT_EN
    output logic [7*((WIDTH+3)/4)-1:0] AhexOut,
    output logic [7*((WIDTH+3)/4)-1:0] BhexOut,
`endif
    output logic             Done
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_HOLD} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next, b_reg, b_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2:0]         f_reg, f_next;
    logic [1:0]         r_reg, r_next;
    logic               busy_reg, busy_next, done_reg, done_next;

    logic [DIGIT-1:0]   dig_a, dig_b, dig_r, top_a, top_b;
    logic [WIDTH-1:0]   top_a_ext, top_b_ext, shift_a, shift_b;

    // Bitwise function on one digit: low two bits pick the base op, bit 2 inverts.
    function automatic logic [DIGIT-1:0] apply_f(input logic [2:0] fs,
                                                 input logic [DIGIT-1:0] a,
                                                 input logic [DIGIT-1:0] b);
        logic [DIGIT-1:0] base;
        case (fs[1:0])
            2'b00:   base = a & b;
            2'b01:   base = a | b;
            2'b10:   base = a ^ b;
            default: base = '1;
        endcase
        return fs[2] ? ~base : base;
    endfunction

    // Digit datapath: compute r on the low digits and build the shifted registers.
    always_comb begin
        dig_a = a_reg[DIGIT-1:0];
        dig_b = b_reg[DIGIT-1:0];
        dig_r = apply_f(f_reg, dig_a, dig_b);
        case (r_reg)
            2'b00:   begin top_a = dig_a; top_b = dig_b; end
            2'b01:   begin top_a = dig_a; top_b = dig_r; end
            2'b10:   begin top_a = dig_r; top_b = dig_b; end
            default: begin top_a = dig_b; top_b = dig_a; end
        endcase
        top_a_ext = '0;
        top_b_ext = '0;
        top_a_ext[DIGIT-1:0] = top_a;
        top_b_ext[DIGIT-1:0] = top_b;
        // Shift-based form stays legal even when WIDTH equals DIGIT.
        shift_a = (a_reg >> DIGIT) | (top_a_ext << (WIDTH - DIGIT));
        shift_b = (b_reg >> DIGIT) | (top_b_ext << (WIDTH - DIGIT));
    end

    // Next-state and register-update logic; status flags follow the next state
    // so Busy/Done come straight out of flops.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        f_next     = f_reg;
        r_next     = r_reg;
        case (state_reg)
            S_IDLE: begin
                if (LoadA) a_next = Din;
                if (LoadB) b_next = Din;
                // A load in the same cycle takes priority over starting.
                if (Execute && !LoadA && !LoadB) begin
                    f_next     = F;
                    r_next     = R;
                    cnt_next   = '0;
                    state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                a_next   = shift_a;
                b_next   = shift_b;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(STEPS - 1)) state_next = S_HOLD;
            end
            S_HOLD: begin
                // Wait for Execute to drop so one request runs one operation.
                if (!Execute) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        busy_next = (state_next == S_COMPUTE);
        done_next = (state_next == S_HOLD);
    end

    // State and datapath registers; reset discards any partial shift.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            f_reg     <= '0;
            r_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
            f_reg     <= f_next;
            r_reg     <= r_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign Aval = a_reg;
    assign Bval = b_reg;
    assign Busy = busy_reg;
    assign Done = done_reg;

`ifdef LOGIC_PROC_HEX_OUT_EN
    localparam int NIB = (WIDTH + 3) / 4;

    logic [4*NIB-1:0] a_pad, b_pad;
    logic [7*NIB-1:0] a_seg, b_seg, a_hex_reg, b_hex_reg;

    // Active-low seven-segment pattern, segment order gfedcba.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] on;
        case (n)
            4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
            4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
            4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
            4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    // Zero-pad registers to a whole number of nibbles.
    always_comb begin
        a_pad = '0;
        b_pad = '0;
        a_pad[WIDTH-1:0] = a_reg;
        b_pad[WIDTH-1:0] = b_reg;
    end

    for (genvar gi = 0; gi < NIB; gi++) begin : g_seg
        assign a_seg[gi*7 +: 7] = seg7(a_pad[gi*4 +: 4]);
        assign b_seg[gi*7 +: 7] = seg7(b_pad[gi*4 +: 4]);
    end

    // Registered display codes, blank (all segments off) in reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_hex_reg <= '1;
            b_hex_reg <= '1;
        end else begin
            a_hex_reg <= a_seg;
            b_hex_reg <= b_seg;
        end
    end

    assign AhexOut = a_hex_reg;
    assign BhexOut = b_hex_reg;
`endif

endmodule
